// File: rtl/psram_pkg.sv
// rtl/psram_pkg.sv - shared opcodes, FSM states, phase lengths and strobe helpers for the PSRAM QPI bridge
package psram_pkg;

  localparam logic [7:0] PSRAM_OP_QREAD  = 8'hEB;
  localparam logic [7:0] PSRAM_OP_QWRITE = 8'h38;

  localparam int CMD_NIBBLES  = 2;
  localparam int ADDR_NIBBLES = 6;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_WAIT,
    ST_RDATA,
    ST_WDATA,
    ST_DONE
  } state_t;

  // Only contiguous, non-empty byte masks map onto a single PSRAM burst.
  function automatic logic strb_legal(input logic [3:0] s);
    case (s)
      4'h1, 4'h2, 4'h4, 4'h8, 4'h3, 4'h6, 4'hC, 4'h7, 4'hE, 4'hF: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [1:0] strb_low(input logic [3:0] s);
    casez (s)
      4'b???1: return 2'd0;
      4'b??10: return 2'd1;
      4'b?100: return 2'd2;
      default: return 2'd3;
    endcase
  endfunction

  function automatic logic [2:0] strb_count(input logic [3:0] s);
    return 3'(s[0]) + 3'(s[1]) + 3'(s[2]) + 3'(s[3]);
  endfunction

  function automatic logic [31:0] byte_swap(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

endpackage

// File: rtl/psram_sck_gen.sv
// rtl/psram_sck_gen.sv - SCK at clock/2 with phase strobes and per-phase SCK cycle counter
module psram_sck_gen (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       run,
  input  logic [4:0] len,
  output logic       sck,
  output logic       ph0,
  output logic       ph1,
  output logic       tc
);

  logic       phase;
  logic [4:0] cnt;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      phase <= 1'b0;
      cnt   <= 5'd0;
    end else if (!run) begin
      phase <= 1'b0;
      cnt   <= 5'd0;
    end else if (!phase) begin
      phase <= 1'b1;
    end else begin
      phase <= 1'b0;
      cnt   <= tc ? 5'd0 : cnt + 5'd1;
    end
  end

  assign sck = phase;
  assign ph0 = run & ~phase;
  assign ph1 = run & phase;
  // tc marks the clock that ends the last SCK cycle of the current phase
  assign tc  = ph1 && (cnt == len - 5'd1);

endmodule

// File: rtl/psram_qpi_ctrl.sv
// rtl/psram_qpi_ctrl.sv - APB slave issuing EBh quad reads / 38h quad writes to a QPI PSRAM
// Build macro PSRAM_CMD_SERIAL_EN: opcode sent one bit per SCK on dio_out[0] over CMD_SERIAL_CYC cycles.
module psram_qpi_ctrl
  import psram_pkg::*;
#(
  parameter int CMD_SERIAL_CYC = 8,
  parameter int RD_DUMMY       = 7
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        psel,
  input  logic        penable,
  input  logic        pwrite,
  input  logic [31:0] paddr,
  input  logic [31:0] pwdata,
  input  logic [3:0]  pstrb,
  output logic [31:0] prdata,
  output logic        pready,
  output logic        pslverr,
  output logic        sck,
  output logic        ce_n,
  output logic [3:0]  dio_out,
  output logic        dio_oe,
  input  logic [3:0]  dio_in
);

`ifdef PSRAM_CMD_SERIAL_EN
  localparam logic [4:0] CMD_LEN = 5'(CMD_SERIAL_CYC);
`else
  localparam logic [4:0] CMD_LEN = 5'(CMD_NIBBLES);
  localparam int unused_serial_cyc = CMD_SERIAL_CYC;
`endif

  state_t      state, nxt;
  logic        run, ph0, ph1, tc, start;
  logic [4:0]  len;
  logic        is_wr, err_q;
  logic [7:0]  cmd_sh;
  logic [23:0] addr_sh;
  logic [31:0] data_sh, rd_sh, rd_data;
  logic [3:0]  wr_len;
  logic [1:0]  lane_lo;
  logic        unused_bits;

  assign lane_lo     = strb_low(pstrb);
  assign unused_bits = ^{paddr[31:24], paddr[1:0]};

  psram_sck_gen u_sck_gen (
    .clock   (clock),
    .reset_n (reset_n),
    .run     (run),
    .len     (len),
    .sck     (sck),
    .ph0     (ph0),
    .ph1     (ph1),
    .tc      (tc)
  );

  // The chip is selected exactly while the SCK generator is running a phase.
  assign ce_n   = ~(ph0 | ph1);
  assign prdata = rd_data;

  always_comb begin
    run = 1'b0;
    len = 5'd0;
    case (state)
      ST_CMD:   begin run = 1'b1; len = CMD_LEN;               end
      ST_ADDR:  begin run = 1'b1; len = 5'(ADDR_NIBBLES);      end
      ST_WAIT:  begin run = 1'b1; len = 5'(RD_DUMMY);          end
      ST_RDATA: begin run = 1'b1; len = 5'd8;                  end
      ST_WDATA: begin run = 1'b1; len = {1'b0, wr_len};        end
      default:  begin run = 1'b0; len = 5'd0;                  end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= nxt;
  end

  always_comb begin
    nxt     = state;
    start   = 1'b0;
    dio_oe  = 1'b0;
    dio_out = 4'h0;
    pready  = 1'b0;
    pslverr = 1'b0;
    case (state)
      ST_IDLE: begin
        if (psel && penable) begin
          start = 1'b1;
          nxt   = (pwrite && !strb_legal(pstrb)) ? ST_DONE : ST_CMD;
        end
      end
      ST_CMD: begin
        dio_oe = 1'b1;
`ifdef PSRAM_CMD_SERIAL_EN
        dio_out = {3'b000, cmd_sh[7]};
`else
        dio_out = cmd_sh[7:4];
`endif
        if (tc) nxt = ST_ADDR;
      end
      ST_ADDR: begin
        dio_oe  = 1'b1;
        dio_out = addr_sh[23:20];
        if (tc) nxt = is_wr ? ST_WDATA : ST_WAIT;
      end
      ST_WAIT:  if (tc) nxt = ST_RDATA;
      ST_RDATA: if (tc) nxt = ST_DONE;
      ST_WDATA: begin
        dio_oe  = 1'b1;
        dio_out = data_sh[31:28];
        if (tc) nxt = ST_DONE;
      end
      ST_DONE: begin
        pready  = 1'b1;
        pslverr = err_q;
        nxt     = ST_IDLE;
      end
      default: nxt = ST_IDLE;
    endcase
  end

  // Shift registers advance on the clock that ends SCK phase 1, so dio_out
  // only changes as phase 0 begins and dio_in is captured on the falling edge.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      is_wr   <= 1'b0;
      err_q   <= 1'b0;
      cmd_sh  <= 8'h00;
      addr_sh <= 24'h0;
      data_sh <= 32'h0;
      wr_len  <= 4'h0;
      rd_sh   <= 32'h0;
      rd_data <= 32'h0;
    end else if (start) begin
      is_wr   <= pwrite;
      err_q   <= pwrite && !strb_legal(pstrb);
      cmd_sh  <= pwrite ? PSRAM_OP_QWRITE : PSRAM_OP_QREAD;
      addr_sh <= {paddr[23:2], pwrite ? lane_lo : 2'b00};
      data_sh <= byte_swap(pwdata) << {lane_lo, 3'b000};
      wr_len  <= {strb_count(pstrb), 1'b0};
    end else if (ph1) begin
      case (state)
`ifdef PSRAM_CMD_SERIAL_EN
        ST_CMD:   cmd_sh <= {cmd_sh[6:0], 1'b0};
`else
        ST_CMD:   cmd_sh <= {cmd_sh[3:0], 4'h0};
`endif
        ST_ADDR:  addr_sh <= {addr_sh[19:0], 4'h0};
        ST_WDATA: data_sh <= {data_sh[27:0], 4'h0};
        ST_RDATA: begin
          rd_sh <= {rd_sh[27:0], dio_in};
          if (tc) rd_data <= byte_swap({rd_sh[27:0], dio_in});
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_psram_qpi_ctrl.sv
// tb/tb_psram_qpi_ctrl.sv - directed self-checking bench for psram_qpi_ctrl with a behavioural PSRAM
module tb_psram_qpi_ctrl;

`ifdef PSRAM_CMD_SERIAL_EN
  localparam int CMDC = 8;
`else
  localparam int CMDC = 2;
`endif
  localparam int DUMMY = 7;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
  logic [31:0] paddr = 32'h0, pwdata = 32'h0;
  logic [3:0]  pstrb = 4'h0;
  logic [3:0]  dio_in = 4'h0;
  logic [31:0] prdata;
  logic        pready, pslverr, sck, ce_n, dio_oe;
  logic [3:0]  dio_out;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  psram_qpi_ctrl dut (
    .clock   (clock),
    .reset_n (reset_n),
    .psel    (psel),
    .penable (penable),
    .pwrite  (pwrite),
    .paddr   (paddr),
    .pwdata  (pwdata),
    .pstrb   (pstrb),
    .prdata  (prdata),
    .pready  (pready),
    .pslverr (pslverr),
    .sck     (sck),
    .ce_n    (ce_n),
    .dio_out (dio_out),
    .dio_oe  (dio_oe),
    .dio_in  (dio_in)
  );

  // Behavioural PSRAM: records every nibble seen on a rising SCK edge.
  logic [3:0] nib [0:63];
  logic       oe_rec [0:63];
  logic [7:0] mem [0:255];
  int nib_cnt = 0;
  int sck_rises = 0;
  int ce_falls = 0;

  function automatic logic [7:0] model_op();
    logic [7:0] op;
`ifdef PSRAM_CMD_SERIAL_EN
    op = 8'h0;
    for (int i = 0; i < 8; i++) op = {op[6:0], nib[i][0]};
`else
    op = {nib[0], nib[1]};
`endif
    return op;
  endfunction

  function automatic logic [23:0] model_addr();
    logic [23:0] a;
    a = 24'h0;
    for (int i = 0; i < 6; i++) a = {a[19:0], nib[CMDC + i]};
    return a;
  endfunction

  initial for (int i = 0; i < 256; i++) mem[i] = 8'h00;

  always @(negedge ce_n) begin
    nib_cnt  = 0;
    ce_falls = ce_falls + 1;
  end

  always @(posedge sck) begin : model_rise
    int k, j;
    logic [23:0] a;
    logic [7:0]  b;
    k = nib_cnt;
    if (k < 64) begin
      nib[k]    = dio_out;
      oe_rec[k] = dio_oe;
    end
    nib_cnt   = nib_cnt + 1;
    sck_rises = sck_rises + 1;
    if (k >= CMDC + 6 + DUMMY && k < CMDC + 6 + DUMMY + 8 && model_op() == 8'hEB) begin
      j = k - (CMDC + 6 + DUMMY);
      a = model_addr() + 24'(j / 2);
      b = mem[a[7:0]];
      dio_in = (j % 2 == 1) ? b[3:0] : b[7:4];
    end
  end

  always @(posedge ce_n) begin : model_commit
    logic [23:0] a;
    if (nib_cnt >= CMDC + 8 && nib_cnt < 64 && model_op() == 8'h38) begin
      for (int bi = 0; bi < (nib_cnt - CMDC - 6) / 2; bi++) begin
        a = model_addr() + 24'(bi);
        mem[a[7:0]] = {nib[CMDC + 6 + 2 * bi], nib[CMDC + 7 + 2 * bi]};
      end
    end
  end

  task automatic apb_start(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] strb);
    @(negedge clock);
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = data; pstrb = strb;
    @(negedge clock);
    penable = 1'b1;
  endtask

  task automatic apb_wait(output int lat, output logic [31:0] rd, output logic err);
    lat = 0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clock); #1;
      lat++;
      if (pready === 1'b1) break;
    end
    rd  = prdata;
    err = pslverr;
    checks++;
    if (pready !== 1'b1) begin
      errors++; $display("FAIL pready_timeout: pready=%b after %0d clocks, required 1", pready, lat);
    end
    checks++;
    if (ce_n !== 1'b1 || sck !== 1'b0) begin
      errors++; $display("FAIL done_pins: ce_n=%b sck=%b, required ce_n=1 sck=0", ce_n, sck);
    end
    psel = 1'b0; penable = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    checks++; if (sck !== 1'b0)     begin errors++; $display("FAIL rst_sck: got %b need 0", sck); end
    checks++; if (ce_n !== 1'b1)    begin errors++; $display("FAIL rst_ce_n: got %b need 1", ce_n); end
    checks++; if (dio_oe !== 1'b0)  begin errors++; $display("FAIL rst_dio_oe: got %b need 0", dio_oe); end
    checks++; if (dio_out !== 4'h0) begin errors++; $display("FAIL rst_dio_out: got %h need 0", dio_out); end
    checks++; if (pready !== 1'b0)  begin errors++; $display("FAIL rst_pready: got %b need 0", pready); end
    checks++; if (pslverr !== 1'b0) begin errors++; $display("FAIL rst_pslverr: got %b need 0", pslverr); end
    checks++; if (prdata !== 32'h0) begin errors++; $display("FAIL rst_prdata: got %h need 0", prdata); end
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  task automatic test_word_write();
    int lat; logic [31:0] rd; logic err; int bad;
    logic [3:0] exp_w [14] = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h1, 4'h0,
                               4'hA, 4'hA, 4'hB, 4'hB, 4'hC, 4'hC, 4'hD, 4'hD};
    apb_start(1'b1, 32'h8000_0010, 32'hDDCC_BBAA, 4'hF);
    apb_wait(lat, rd, err);
    checks++; if (lat != 1 + 2 * (CMDC + 6 + 8)) begin errors++; $display("FAIL ww_latency: got %0d need %0d", lat, 1 + 2 * (CMDC + 14)); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL ww_pslverr: got %b need 0", err); end
    checks++; if (nib_cnt != CMDC + 14) begin errors++; $display("FAIL ww_sck_cycles: got %0d need %0d", nib_cnt, CMDC + 14); end
    checks++; if (model_op() !== 8'h38) begin errors++; $display("FAIL ww_opcode: got %h need 38", model_op()); end
    for (int i = 0; i < 14; i++) begin
      checks++;
      if (nib[CMDC + i] !== exp_w[i]) begin errors++; $display("FAIL ww_nibble%0d: got %h need %h", i, nib[CMDC + i], exp_w[i]); end
    end
    bad = 0;
    for (int i = 0; i < CMDC + 14; i++) if (oe_rec[i] !== 1'b1) bad++;
    checks++; if (bad != 0) begin errors++; $display("FAIL ww_dio_oe: %0d cycles undriven, need 0", bad); end
  endtask

  task automatic test_word_read();
    int lat; logic [31:0] rd; logic err; int bad;
    apb_start(1'b0, 32'h8000_0010, 32'h0, 4'h0);
    apb_wait(lat, rd, err);
    checks++; if (lat != 1 + 2 * (CMDC + 6 + DUMMY + 8)) begin errors++; $display("FAIL wr_latency: got %0d need %0d", lat, 1 + 2 * (CMDC + 21)); end
    checks++; if (rd !== 32'hDDCC_BBAA) begin errors++; $display("FAIL wr_prdata: got %h need ddccbbaa", rd); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL wr_pslverr: got %b need 0", err); end
    checks++; if (model_op() !== 8'hEB) begin errors++; $display("FAIL wr_opcode: got %h need eb", model_op()); end
    checks++; if (model_addr() !== 24'h000010) begin errors++; $display("FAIL wr_addr: got %h need 000010", model_addr()); end
    bad = 0;
    for (int i = 0; i < CMDC + 6 + DUMMY + 8; i++) if (oe_rec[i] !== (i < CMDC + 6)) bad++;
    checks++; if (bad != 0) begin errors++; $display("FAIL wr_dio_oe: %0d cycles wrong, need 0", bad); end
`ifdef PSRAM_CMD_SERIAL_EN
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (nib[i] !== {3'b000, (i == 3 || i == 5) ? 1'b0 : 1'b1})
        begin errors++; $display("FAIL wr_serial_bit%0d: got %h", i, nib[i]); end
    end
`endif
  endtask

  task automatic test_byte_write();
    int lat; logic [31:0] rd; logic err;
    apb_start(1'b1, 32'h8000_0020, 32'h0055_0000, 4'h4);
    apb_wait(lat, rd, err);
    checks++; if (lat != 1 + 2 * (CMDC + 6 + 2)) begin errors++; $display("FAIL bw_latency: got %0d need %0d", lat, 1 + 2 * (CMDC + 8)); end
    checks++; if (model_addr() !== 24'h000022) begin errors++; $display("FAIL bw_addr: got %h need 000022", model_addr()); end
    checks++; if (nib_cnt != CMDC + 8) begin errors++; $display("FAIL bw_sck_cycles: got %0d need %0d", nib_cnt, CMDC + 8); end
    checks++; if ({nib[CMDC + 6], nib[CMDC + 7]} !== 8'h55) begin errors++; $display("FAIL bw_data: got %h%h need 55", nib[CMDC + 6], nib[CMDC + 7]); end
    apb_start(1'b0, 32'h8000_0020, 32'h0, 4'h0);
    apb_wait(lat, rd, err);
    checks++; if (rd !== 32'h0055_0000) begin errors++; $display("FAIL bw_readback: got %h need 00550000", rd); end
  endtask

  task automatic test_illegal_strb();
    int lat; logic [31:0] rd; logic err; int r0, f0;
    logic [3:0] bad_strb [3] = '{4'h5, 4'h0, 4'hA};
    for (int t = 0; t < 3; t++) begin
      r0 = sck_rises; f0 = ce_falls;
      apb_start(1'b1, 32'h8000_0040, 32'hFFFF_FFFF, bad_strb[t]);
      apb_wait(lat, rd, err);
      checks++; if (lat != 1) begin errors++; $display("FAIL ill_latency strb=%h: got %0d need 1", bad_strb[t], lat); end
      checks++; if (err !== 1'b1) begin errors++; $display("FAIL ill_pslverr strb=%h: got %b need 1", bad_strb[t], err); end
      checks++; if (sck_rises != r0 || ce_falls != f0) begin errors++; $display("FAIL ill_pins strb=%h: sck rises %0d ce falls %0d, need 0", bad_strb[t], sck_rises - r0, ce_falls - f0); end
    end
  endtask

  task automatic test_reset_mid();
    int lat; logic [31:0] rd; logic err;
    apb_start(1'b0, 32'h8000_0010, 32'h0, 4'h0);
    repeat (2 * (CMDC + 6 + DUMMY) + 4) @(posedge clock);
    #3;
    checks++; if (ce_n !== 1'b0 || sck !== 1'b1) begin errors++; $display("FAIL rm_pre: ce_n=%b sck=%b need 0 1", ce_n, sck); end
    reset_n = 1'b0;
    #1;
    checks++; if (ce_n !== 1'b1)   begin errors++; $display("FAIL rm_ce_n: got %b need 1", ce_n); end
    checks++; if (sck !== 1'b0)    begin errors++; $display("FAIL rm_sck: got %b need 0", sck); end
    checks++; if (dio_oe !== 1'b0) begin errors++; $display("FAIL rm_dio_oe: got %b need 0", dio_oe); end
    checks++; if (pready !== 1'b0) begin errors++; $display("FAIL rm_pready: got %b need 0", pready); end
    psel = 1'b0; penable = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    apb_start(1'b0, 32'h8000_0010, 32'h0, 4'h0);
    apb_wait(lat, rd, err);
    checks++; if (rd !== 32'hDDCC_BBAA) begin errors++; $display("FAIL rm_reread: got %h need ddccbbaa", rd); end
  endtask

  task automatic test_back_to_back();
    int lat; logic [31:0] rd; logic err;
    apb_start(1'b1, 32'h8000_0040, 32'h00BE_EF00, 4'h6);
    apb_wait(lat, rd, err);
    checks++; if (model_addr() !== 24'h000041) begin errors++; $display("FAIL bb_addr: got %h need 000041", model_addr()); end
    apb_start(1'b0, 32'h8000_0040, 32'h0, 4'h0);
    checks++; if (pready !== 1'b0) begin errors++; $display("FAIL bb_pready_idle: got %b need 0", pready); end
    apb_wait(lat, rd, err);
    checks++; if (lat != 1 + 2 * (CMDC + 6 + DUMMY + 8)) begin errors++; $display("FAIL bb_latency: got %0d need %0d", lat, 1 + 2 * (CMDC + 21)); end
    checks++; if (rd !== 32'h00BE_EF00) begin errors++; $display("FAIL bb_prdata: got %h need 00beef00", rd); end
  endtask

  initial begin
    test_reset();
    test_word_write();
    test_word_read();
    test_byte_write();
    test_illegal_strb();
    test_reset_mid();
    test_back_to_back();
    repeat (2) @(posedge clock);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
